interrupt_controller: RTL

Eight-line priority interrupt controller that sits directly upstream of the CPU. It synchronises raw interrupt lines and latches rising edges as pending requests. It filters them through a mask and an in-service nesting rule, and presents one request at a time with a 16-bit handler vector. The CPU clears the request with an acknowledge and ends service with an end-of-interrupt. A small register port gives software access to the mask, pending and in-service state.

---
 rtl/interrupt_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
`default_nettype none
// interrupt_controller: 8-line priority interrupt controller with nesting,
// mask/pending/in-service registers and a registered handler vector. Rev 1.0
module interrupt_controller #(
  parameter logic [15:0] VECTOR_BASE        = 16'h0010,
  parameter int          VECTOR_STRIDE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  output logic        int_req,
  output logic [15:0] int_vector,
  input  logic        int_ack,
  input  logic        int_eoi,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_we,
  input  logic        reg_re,
  output logic [7:0]  reg_rdata
);

  localparam logic [1:0] ADDR_PENDING    = 2'd0;
  localparam logic [1:0] ADDR_MASK       = 2'd1;
  localparam logic [1:0] ADDR_IN_SERVICE = 2'd2;
  localparam logic [1:0] ADDR_CTRL       = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  sync1_q, sync2_q, edge_q;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  in_service_q, in_service_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic [2:0]  idx_q, idx_d;
  logic        req_q, req_d;
  logic [15:0] vector_q, vector_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [7:0]  rise;
  logic [7:0]  eligible;
  logic [7:0]  eoi_bit;
  logic [3:0]  elig_lo;
  logic [3:0]  isv_lo;
  logic        candidate;
  logic        ack_take;

  // Returns 8 when no bit is set, so an idle in-service set never blocks.
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  assign rise      = sync2_q & ~edge_q;
  assign eligible  = pending_q & ~mask_q;
  assign elig_lo   = lowest_idx(eligible);
  assign isv_lo    = lowest_idx(in_service_q);
  assign candidate = ctrl_en_q && (eligible != 8'h00) && (elig_lo < isv_lo);
  assign ack_take  = (state_q == REQ) && int_ack;
  assign eoi_bit   = int_eoi ? (in_service_q & (~in_service_q + 8'd1)) : 8'h00;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vector_d = vector_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (candidate) begin
          idx_d    = elig_lo[2:0];
          vector_d = VECTOR_BASE + ({13'd0, elig_lo[2:0]} << VECTOR_STRIDE_LOG2);
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Committed request: only the acknowledge can retire it.
        if (int_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (reg_we && (reg_addr == ADDR_PENDING)) pending_d = pending_d & ~reg_wdata;
    if (ack_take) pending_d[idx_q] = 1'b0;
    pending_d = pending_d | rise;

    in_service_d = in_service_q & ~eoi_bit;
    if (ack_take) in_service_d[idx_q] = 1'b1;

    mask_d    = (reg_we && (reg_addr == ADDR_MASK)) ? reg_wdata : mask_q;
    ctrl_en_d = (reg_we && (reg_addr == ADDR_CTRL)) ? reg_wdata[0] : ctrl_en_q;

    rdata_d = rdata_q;
    if (reg_re) begin
      case (reg_addr)
        ADDR_PENDING:    rdata_d = pending_q;
        ADDR_MASK:       rdata_d = mask_q;
        ADDR_IN_SERVICE: rdata_d = in_service_q;
        default:         rdata_d = {7'd0, ctrl_en_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 8'h00;
      sync2_q      <= 8'h00;
      edge_q       <= 8'h00;
      pending_q    <= 8'h00;
      mask_q       <= 8'hFF;
      in_service_q <= 8'h00;
      ctrl_en_q    <= 1'b0;
      idx_q        <= 3'd0;
      req_q        <= 1'b0;
      vector_q     <= 16'h0000;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      sync1_q      <= irq_in;
      sync2_q      <= sync1_q;
      edge_q       <= sync2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      ctrl_en_q    <= ctrl_en_d;
      idx_q        <= idx_d;
      req_q        <= req_d;
      vector_q     <= vector_d;
      rdata_q      <= rdata_d;
    end
  end

  assign int_req    = req_q;
  assign int_vector = vector_q;
  assign reg_rdata  = rdata_q;

endmodule
`default_nettype wire
